// File: rtl/wb_cmd_pkg.sv
// Shared types and bus widths for the Wishbone command initiator.
package wb_cmd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating ack-wait counter; expires on the last allowed wait cycle.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [TW-1:0] o_cnt,
  output logic          o_expired
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_cnt <= '0;
    else if (i_clr)              r_cnt <= '0;
    else if (i_inc && ~&r_cnt)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt     = r_cnt;
  assign o_expired = (r_cnt == LAST);
endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per command, response with
// read data or timeout error on a valid/ready port.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i,
  output logic             busy
);
  state_t           r_state;
  logic             r_cmd_ready, r_busy;
  logic             r_rsp_valid, r_rsp_err;
  logic [WB_DW-1:0] r_rsp_dat;
  logic             r_cyc, r_stb, r_we;
  logic [WB_SW-1:0] r_sel;
  logic [WB_AW-1:0] r_adr;
  logic [WB_DW-1:0] r_dat;

  logic             w_ctr_clr, w_ctr_inc, w_expired;
  logic [TW-1:0]    w_cnt;

  assign w_ctr_clr = (r_state == IDLE) && cmd_valid;
  assign w_ctr_inc = (r_state == BUS) && !wbm_ack_i;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_tmo (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_clr    (w_ctr_clr),
    .i_inc    (w_ctr_inc),
    .o_cnt    (w_cnt),
    .o_expired(w_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_we        <= cmd_we;
          r_adr       <= cmd_adr;
          r_dat       <= cmd_dat;
          r_sel       <= cmd_sel;
          r_cyc       <= 1'b1;
          r_stb       <= 1'b1;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= BUS;
        end
        BUS: begin
          // ack takes priority over a coincident timeout
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_expired) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master against a transaction-level model.
module tb_wb_cmd_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o, ack;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .TW(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One command: slave acks after wait_n wait states (never if wait_n >= TO),
  // consumer withholds rsp_ready for bp cycles.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input int wait_n,
                         input logic [31:0] rdat, input int bp);
    int          stb_cnt, exp_cnt;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err = (wait_n >= TO);
    exp_cnt = exp_err ? TO : wait_n + 1;
    exp_dat = (exp_err || we) ? 32'h0 : rdat;

    chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = wdat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    stb_cnt = 0;
    while (stb && stb_cnt < 40) begin
      chk("bus_cyc", {31'b0, cyc}, 32'd1);
      chk("bus_adr", adr_o, adr);
      chk("bus_we",  {31'b0, we_o}, {31'b0, we});
      chk("bus_sel", {28'b0, sel_o}, {28'b0, sel});
      chk("bus_dat", dat_o, wdat);
      chk("bus_busy", {30'b0, busy, cmd_ready}, 32'd2);
      ack   = (stb_cnt == wait_n);
      dat_i = ack ? rdat : $urandom;
      @(negedge clk);
      ack = 1'b0;
      stb_cnt++;
    end
    chk("stb_cycles", 32'(stb_cnt), 32'(exp_cnt));
    chk("cyc_low", {30'b0, cyc, stb}, 32'd0);
    for (int i = 0; i <= bp; i++) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_err",   {31'b0, rsp_err}, {31'b0, exp_err});
      chk("rsp_dat",   rsp_dat, exp_dat);
      chk("rsp_ready_busy", {30'b0, cmd_ready, busy}, 32'd1);
      if (i < bp) begin
        // stray ack and a premature command must both be ignored
        rsp_ready = 1'b0; ack = 1'($urandom); cmd_valid = 1'($urandom);
        @(negedge clk);
        ack = 1'b0; cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rel_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rel_ready_busy", {30'b0, cmd_ready, busy}, 32'd2);
    chk("rel_cyc", {30'b0, cyc, stb}, 32'd0);
    chk("hold_adr", adr_o, adr);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("stray_ack", {29'b0, cyc, stb, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_bus", {25'b0, cyc, stb, we_o, sel_o}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF, 0);
    run_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'h0000_1234, 0);
    run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 100, 32'h5555_AAAA, 0);
    run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 0);
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'h0BAD_C0DE, 5);
    run_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, TO - 1, 32'h1357_9BDF, 0);
    run_cmd(1'b1, 32'h3000_0018, 32'h1111_2222, 4'h5, TO - 1, 32'h0, 1);

    for (int n = 0; n < 40; n++)
      run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, TO + 3)), $urandom, int'($urandom_range(0, 4)));

    // reset while the strobe is high
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_stb", {30'b0, cyc, stb}, 32'd3);
    #2 rst = 1'b1;
    #1 chk("async_drop", {30'b0, cyc, stb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("post_rst_state", {29'b0, rsp_valid, cmd_ready, busy}, 32'd2);
    chk("post_rst_cyc", {30'b0, cyc, stb}, 32'd0);
    run_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h0000_4321, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
